// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: divides sys_clk down to a step rate and advances an LED_W-bit
// pattern per step in up, down, ping-pong or walking-one mode.
module led_pattern_seq #(
    parameter int CLK_HZ  = 24_000_000,
    parameter int STEP_HZ = 2,
    parameter int LED_W   = 3,
    parameter int LAST    = 6
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             step_in,
    output logic [LED_W-1:0] led,
    output logic             tick,
    output logic             wrap
);

    localparam int DIV = CLK_HZ / STEP_HZ;
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0]    TC     = CW'(DIV - 1);
    localparam logic [CW-1:0]    CNT1   = CW'(1);
    localparam logic [LED_W-1:0] LAST_V = LED_W'(LAST);
    localparam logic [LED_W-1:0] ONE    = LED_W'(1);
    localparam logic [LED_W-1:0] ZERO   = '0;

    typedef enum logic [1:0] {M_UP = 2'b00, M_DOWN = 2'b01, M_PING = 2'b10, M_WALK = 2'b11} mode_t;

    logic [CW-1:0]    cnt;
    mode_t            mode_q;
    mode_t            mode_in;
    logic             dir_dn;
    logic             tc, step;
    logic [LED_W-1:0] led_nxt, led_inc, led_dec, seed;
    logic             dir_nxt, wrap_nxt, one_hot;

    assign mode_in = mode_t'(mode);
    assign tc      = en && (cnt == TC);
    // Coincident prescaler and manual requests collapse into a single step.
    assign step    = tc | step_in;
    assign led_inc = led + ONE;
    assign led_dec = led - ONE;
    assign one_hot = (led != ZERO) && ((led & led_dec) == ZERO);

    always_comb begin
        seed = ZERO;
        case (mode_in)
            M_DOWN:  seed = LAST_V;
            M_WALK:  seed = ONE;
            default: seed = ZERO;
        endcase
    end

    // Out-of-range values reload the seed instead of stepping, without flagging wrap.
    always_comb begin
        led_nxt  = led;
        dir_nxt  = dir_dn;
        wrap_nxt = 1'b0;
        case (mode_q)
            M_UP: begin
                if (led > LAST_V) led_nxt = ZERO;
                else if (led == LAST_V) begin
                    led_nxt  = ZERO;
                    wrap_nxt = 1'b1;
                end else led_nxt = led_inc;
            end
            M_DOWN: begin
                if (led > LAST_V) led_nxt = LAST_V;
                else if (led == ZERO) begin
                    led_nxt  = LAST_V;
                    wrap_nxt = 1'b1;
                end else led_nxt = led_dec;
            end
            M_PING: begin
                if (led > LAST_V) begin
                    led_nxt = ZERO;
                    dir_nxt = 1'b0;
                end else if ((!dir_dn && led != LAST_V) || (dir_dn && led == ZERO)) begin
                    led_nxt = led_inc;
                    dir_nxt = (led_inc == LAST_V);
                end else begin
                    led_nxt  = led_dec;
                    dir_nxt  = (led_dec != ZERO);
                    wrap_nxt = (led == ONE);
                end
            end
            default: begin
                if (!one_hot) led_nxt = ONE;
                else if (led[LED_W-1]) begin
                    led_nxt  = ONE;
                    wrap_nxt = 1'b1;
                end else led_nxt = {led[LED_W-2:0], 1'b0};
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            led    <= '0;
            dir_dn <= 1'b0;
            mode_q <= M_UP;
            tick   <= 1'b0;
            wrap   <= 1'b0;
        end else if (mode_in != mode_q) begin
            mode_q <= mode_in;
            led    <= seed;
            cnt    <= '0;
            dir_dn <= 1'b0;
            tick   <= 1'b0;
            wrap   <= 1'b0;
        end else begin
            if (en) cnt <= tc ? '0 : cnt + CNT1;
            tick <= tc;
            if (step) begin
                led    <= led_nxt;
                dir_dn <= dir_nxt;
                wrap   <= wrap_nxt;
            end else begin
                wrap   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_seq.sv
// Directed bench for led_pattern_seq with DIV=10; a second instance with LAST=3
// covers the ping-pong sequence.
module tb_led_pattern_seq;

    logic       sys_clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       step_in = 1'b0;
    logic [2:0] led, led3;
    logic       tick, wrap, tick3, wrap3;

    int n_chk = 0;
    int n_pass = 0;

    led_pattern_seq #(.CLK_HZ(10), .STEP_HZ(1), .LED_W(3), .LAST(6)) dut (
        .sys_clk(sys_clk), .rst(rst), .en(en), .mode(mode), .step_in(step_in),
        .led(led), .tick(tick), .wrap(wrap));

    led_pattern_seq #(.CLK_HZ(10), .STEP_HZ(1), .LED_W(3), .LAST(3)) dut3 (
        .sys_clk(sys_clk), .rst(rst), .en(en), .mode(mode), .step_in(step_in),
        .led(led3), .tick(tick3), .wrap(wrap3));

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    int pp_led[8]  = '{1, 2, 3, 2, 1, 0, 1, 2};
    int pp_wrap[8] = '{0, 0, 0, 0, 0, 1, 0, 0};
    int wk_led[4]  = '{2, 4, 1, 2};
    int wk_wrap[4] = '{0, 0, 1, 0};
    int nt;

    initial begin
        // reset state
        cyc(1);
        chk("rst_led", int'(led), 0);
        chk("rst_tick", int'(tick), 0);
        chk("rst_wrap", int'(wrap), 0);

        // 1: count up, free running
        rst = 1'b0;
        en  = 1'b1;
        cyc(9);
        chk("up_pre_led", int'(led), 0);
        chk("up_pre_tick", int'(tick), 0);
        cyc(1);
        chk("up_led1", int'(led), 1);
        chk("up_tick1", int'(tick), 1);
        cyc(1);
        chk("up_tick_pulse", int'(tick), 0);
        chk("up_hold1", int'(led), 1);
        for (int k = 2; k <= 6; k++) begin
            cyc(9);
            chk("up_led", int'(led), k);
            chk("up_nowrap", int'(wrap), 0);
            cyc(1);
        end
        cyc(9);
        chk("up_wrap_led", int'(led), 0);
        chk("up_wrap", int'(wrap), 1);
        chk("up_wrap_tick", int'(tick), 1);
        cyc(1);
        chk("up_wrap_pulse", int'(wrap), 0);

        // 2: down mode selected through reset release
        #2 rst = 1'b1;
        mode = 2'b01;
        cyc(1);
        rst = 1'b0;
        cyc(1);
        chk("dn_seed", int'(led), 6);
        chk("dn_seed_wrap", int'(wrap), 0);
        cyc(9);
        chk("dn_hold", int'(led), 6);
        cyc(1);
        chk("dn_led5", int'(led), 5);
        chk("dn_tick", int'(tick), 1);
        for (int k = 4; k >= 0; k--) begin
            cyc(10);
            chk("dn_led", int'(led), k);
            chk("dn_nowrap", int'(wrap), 0);
        end
        cyc(10);
        chk("dn_wrap_led", int'(led), 6);
        chk("dn_wrap", int'(wrap), 1);

        // 3: ping-pong, LAST=3 instance, stepped manually
        en   = 1'b0;
        mode = 2'b10;
        cyc(1);
        chk("pp_seed", int'(led3), 0);
        step_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            chk("pp_led", int'(led3), pp_led[i]);
            chk("pp_wrap", int'(wrap3), pp_wrap[i]);
        end
        step_in = 1'b0;

        // 4: walking one, then switch to up mid-count
        mode = 2'b11;
        cyc(1);
        chk("wk_seed", int'(led), 1);
        step_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            chk("wk_led", int'(led), wk_led[i]);
            chk("wk_wrap", int'(wrap), wk_wrap[i]);
        end
        step_in = 1'b0;
        en = 1'b1;
        cyc(4);
        chk("wk_mid_cnt", int'(dut.cnt), 4);
        mode = 2'b00;
        cyc(1);
        chk("sw_led", int'(led), 0);
        chk("sw_cnt", int'(dut.cnt), 0);

        // 5: pause, manual step, coincident step
        cyc(13);
        chk("ps_led", int'(led), 1);
        en = 1'b0;
        nt = 0;
        repeat (50) begin
            cyc(1);
            if (tick) nt++;
        end
        chk("ps_led_frozen", int'(led), 1);
        chk("ps_cnt_frozen", int'(dut.cnt), 3);
        chk("ps_no_tick", nt, 0);
        step_in = 1'b1;
        cyc(1);
        step_in = 1'b0;
        chk("ps_step", int'(led), 2);
        chk("ps_step_cnt", int'(dut.cnt), 3);
        cyc(5);
        chk("ps_step_once", int'(led), 2);
        en = 1'b1;
        cyc(6);
        chk("co_pre", int'(led), 2);
        step_in = 1'b1;
        cyc(1);
        step_in = 1'b0;
        chk("co_one_step", int'(led), 3);
        chk("co_tick", int'(tick), 1);
        cyc(1);
        chk("co_hold", int'(led), 3);

        // 6: async reset in the middle of a step period
        cyc(9);
        chk("rs_led4", int'(led), 4);
        cyc(7);
        chk("rs_cnt7", int'(dut.cnt), 7);
        #2 rst = 1'b1;
        #1;
        chk("rs_led_async", int'(led), 0);
        chk("rs_tick_async", int'(tick), 0);
        chk("rs_wrap_async", int'(wrap), 0);
        chk("rs_cnt_async", int'(dut.cnt), 0);
        cyc(1);
        rst = 1'b0;
        cyc(9);
        chk("rs_resume_hold", int'(led), 0);
        chk("rs_resume_notick", int'(tick), 0);
        cyc(1);
        chk("rs_resume_led", int'(led), 1);
        chk("rs_resume_tick", int'(tick), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
